// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO built on an external 2**ADDR_W x DATA_W dual-port RAM,
// with a 2-entry skid buffer that hides the RAM read latency. Optional high-water mark: FIFO_HWM_EN.
module ram_fifo_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty
`ifdef FIFO_HWM_EN
  ,
  output logic [ADDR_W+1:0] hwm,
  input  logic              hwm_clr
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic              inflight;
  logic [1:0]        skid_cnt;
  logic [DATA_W-1:0] skid_head;
  logic [DATA_W-1:0] skid_tail;
  logic              push;
  logic              pop;
  logic              rd_issue;
  logic [2:0]        occ_next;

  // A read is only issued if its returning word is guaranteed a free skid slot.
  always_comb begin
    full      = (mem_cnt == DEPTH_CNT);
    in_ready  = !full;
    push      = in_valid & in_ready;
    out_valid = (skid_cnt != 2'd0);
    out_data  = skid_head;
    pop       = out_valid & out_ready;
    occ_next  = 3'(skid_cnt) + 3'(inflight) - 3'(pop);
    rd_issue  = (mem_cnt != '0) && (occ_next < 3'd2);

    ram_write_en   = push;
    ram_write_addr = wr_ptr;
    ram_write_data = in_data;
    ram_read_en    = rd_issue;
    ram_read_addr  = rd_ptr;

    count = (ADDR_W + 2)'(mem_cnt) + (ADDR_W + 2)'(inflight) + (ADDR_W + 2)'(skid_cnt);
    empty = (count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
      inflight <= rd_issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt <= '0;
    end else begin
      case ({push, rd_issue})
        2'b10:   mem_cnt <= mem_cnt + (ADDR_W + 1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (ADDR_W + 1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  // Returning RAM data lands behind whatever survives this cycle's pop, keeping order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_cnt  <= 2'd0;
      skid_head <= '0;
      skid_tail <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid_head <= ram_read_data;
          else                  skid_tail <= ram_read_data;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid_head <= skid_tail;
          skid_cnt  <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid_head <= ram_read_data;
          end else begin
            skid_head <= skid_tail;
            skid_tail <= ram_read_data;
          end
        end
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

`ifdef FIFO_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            hwm <= '0;
    else if (hwm_clr)      hwm <= count;
    else if (count > hwm)  hwm <= count;
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: randomized self-checking bench for ram_fifo_ctrl with a behavioural RAM
// and a queue-based reference model; hwm checks build only when FIFO_HWM_EN is defined.
module tb_ram_fifo_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 256;
  localparam int CAP    = DEPTH + 2;
  localparam int CW     = ADDR_W + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [DATA_W-1:0] ram_write_data;
  logic              ram_read_en;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_read_data;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
`ifdef FIFO_HWM_EN
  logic [CW-1:0]     hwm;
  logic              hwm_clr;
`endif

  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic [DATA_W-1:0] model_q [$];
  int n_cmp  = 0;
  int n_fail = 0;
  logic              last_push;
  logic              last_pop;
  logic [DATA_W-1:0] last_got;
  logic [DATA_W-1:0] last_exp;

  ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_read_en(ram_read_en), .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
    .count(count), .full(full), .empty(empty)
`ifdef FIFO_HWM_EN
    , .hwm(hwm), .hwm_clr(hwm_clr)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with a registered read.
  always @(posedge clk) begin
    if (ram_write_en) ram_mem[ram_write_addr] <= ram_write_data;
    if (ram_read_en)  ram_read_data <= ram_mem[ram_read_addr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "[TB] watchdog");
  end

  // One clock: record the handshakes seen before the edge and advance the reference queue.
  task automatic tick();
    logic [DATA_W-1:0] w;
    #1;
    last_push = in_valid && in_ready;
    last_pop  = out_valid && out_ready;
    last_got  = out_data;
    last_exp  = (model_q.size() > 0) ? model_q[0] : 'x;
    w = in_data;
    @(posedge clk);
    if (last_pop && model_q.size() > 0) void'(model_q.pop_front());
    if (last_push) model_q.push_back(w);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef FIFO_HWM_EN
    hwm_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({empty, full, in_ready, out_valid, ram_write_en, ram_read_en} !== 6'b101000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags_in_reset: got %b want 101000",
               {empty, full, in_ready, out_valid, ram_write_en, ram_read_en});
    end
    rst_n = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if ({empty, full, in_ready, out_valid, ram_write_en, ram_read_en} !== 6'b101000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags_idle: got %b want 101000",
               {empty, full, in_ready, out_valid, ram_write_en, ram_read_en});
    end
    n_cmp++;
    if (count !== '0 || out_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_count_data: got count=%0d data=%h want 0/0", count, out_data);
    end
    n_cmp++;
    if ({ram_write_addr, ram_read_addr} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_ram_addr: got wa=%h ra=%h want 00/00", ram_write_addr, ram_read_addr);
    end
  endtask

  task automatic test_single_push();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h3;
    #1;
    n_cmp++;
    if ({ram_write_en, ram_write_addr, ram_write_data} !== {1'b1, 8'h00, 4'h3}) begin
      n_fail++;
      $display("[TB] FAIL single_write: got en=%b a=%h d=%h want 1/00/3",
               ram_write_en, ram_write_addr, ram_write_data);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({ram_read_en, ram_read_addr, out_valid, count} !== {1'b1, 8'h00, 1'b0, 10'd1}) begin
      n_fail++;
      $display("[TB] FAIL single_read_issue: got ren=%b ra=%h ov=%b cnt=%0d want 1/00/0/1",
               ram_read_en, ram_read_addr, out_valid, count);
    end
    tick();
    n_cmp++;
    if ({ram_read_en, out_valid, count} !== {1'b0, 1'b0, 10'd1}) begin
      n_fail++;
      $display("[TB] FAIL single_return_cycle: got ren=%b ov=%b cnt=%0d want 0/0/1",
               ram_read_en, out_valid, count);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_data, count} !== {1'b1, 4'h3, 10'd1}) begin
      n_fail++;
      $display("[TB] FAIL single_head: got ov=%b d=%h cnt=%0d want 1/3/1", out_valid, out_data, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (!last_pop || last_got !== 4'h3 || empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_pop: got pop=%b d=%h empty=%b want 1/3/1", last_pop, last_got, empty);
    end
  endtask

  // Fill to capacity with out_ready low; the write address must follow the push index mod DEPTH.
  task automatic test_fill();
    int pushed = 0;
    int guard = 0;
    int base;
    base = 1;
    out_ready = 1'b0;
    while (pushed < CAP && guard < 400) begin
      in_valid = 1'b1;
      in_data  = 4'(pushed % 16);
      #1;
      n_cmp++;
      if (count !== CW'(model_q.size()) || full !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL fill_status: got cnt=%0d full=%b rdy=%b want %0d/0/1",
                 count, full, in_ready, model_q.size());
      end
      n_cmp++;
      if (ram_write_en !== 1'b1 || ram_write_addr !== ADDR_W'((pushed + base) % DEPTH)) begin
        n_fail++;
        $display("[TB] FAIL fill_waddr: got en=%b a=%h want 1/%h", ram_write_en, ram_write_addr,
                 ADDR_W'((pushed + base) % DEPTH));
      end
      tick();
      if (last_push) pushed++;
      guard++;
    end
    n_cmp++;
    if (pushed != CAP) begin
      n_fail++;
      $display("[TB] FAIL fill_accepted: got %0d want %0d", pushed, CAP);
    end
    repeat (3) begin
      in_valid = 1'b1;
      #1;
      n_cmp++;
      if ({full, in_ready, ram_write_en, out_valid, out_data, count} !== {3'b100, 1'b1, 4'h0, 10'd258}) begin
        n_fail++;
        $display("[TB] FAIL full_hold: got full=%b rdy=%b wen=%b ov=%b d=%h cnt=%0d want 1/0/0/1/0/258",
                 full, in_ready, ram_write_en, out_valid, out_data, count);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    int k = 0;
    int guard = 0;
    out_ready = 1'b1;
    while (model_q.size() > 0 && guard < 400) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || count !== CW'(model_q.size())) begin
        n_fail++;
        $display("[TB] FAIL drain_rate: got ov=%b cnt=%0d want 1/%0d", out_valid, count, model_q.size());
      end
      tick();
      if (last_pop) begin
        n_cmp++;
        if (last_got !== 4'(k % 16)) begin
          n_fail++;
          $display("[TB] FAIL drain_order[%0d]: got %h want %h", k, last_got, 4'(k % 16));
        end
        k++;
      end
      guard++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (k != CAP || {empty, out_valid} !== 2'b10 || count !== '0) begin
      n_fail++;
      $display("[TB] FAIL drain_end: got pops=%0d empty=%b ov=%b cnt=%0d want %0d/1/0/0",
               k, empty, out_valid, count, CAP);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int recv = 0;
    int guard = 0;
    while ((sent < 1000 || model_q.size() > 0) && guard < 6000) begin
      in_valid  = (sent < 1000);
      in_data   = 4'($urandom);
      out_ready = (sent >= 1000) ? 1'b1 : 1'($urandom % 2);
      #1;
      n_cmp++;
      if (count !== CW'(model_q.size()) || count > CW'(CAP)) begin
        n_fail++;
        $display("[TB] FAIL stream_count: got %0d want %0d (max %0d)", count, model_q.size(), CAP);
      end
      tick();
      if (last_push) sent++;
      if (last_pop) begin
        recv++;
        n_cmp++;
        if (last_got !== last_exp) begin
          n_fail++;
          $display("[TB] FAIL stream_data[%0d]: got %h want %h", recv, last_got, last_exp);
        end
      end
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (sent != 1000 || recv != 1000 || empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stream_totals: got sent=%0d recv=%0d empty=%b want 1000/1000/1", sent, recv, empty);
    end
  endtask

  task automatic test_midstream_reset();
    int guard = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (10) begin
      in_data = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (count !== 10'd10) begin
      n_fail++;
      $display("[TB] FAIL midreset_pre_count: got %0d want 10", count);
    end
    rst_n = 1'b0;
    #1;
    model_q.delete();
    n_cmp++;
    if ({empty, full, in_ready, out_valid, ram_write_en, ram_read_en} !== 6'b101000 ||
        count !== '0 || out_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got flags=%b cnt=%0d d=%h want 101000/0/0",
               {empty, full, in_ready, out_valid, ram_write_en, ram_read_en}, count, out_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 4'hA;
    #1;
    n_cmp++;
    if (ram_write_addr !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL midreset_waddr: got %h want 00", ram_write_addr);
    end
    tick();
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && guard < 6) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 4'hA || count !== 10'd1) begin
      n_fail++;
      $display("[TB] FAIL midreset_first: got ov=%b d=%h cnt=%0d want 1/a/1", out_valid, out_data, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef FIFO_HWM_EN
  task automatic test_hwm();
    int guard = 0;
    hwm_clr = 1'b1;
    tick();
    hwm_clr = 1'b0;
    n_cmp++;
    if (hwm !== '0) begin
      n_fail++;
      $display("[TB] FAIL hwm_clear_start: got %0d want 0", hwm);
    end
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (20) begin
      in_data = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    while (model_q.size() > 0 && guard < 60) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (hwm !== 10'd20 || count !== '0) begin
      n_fail++;
      $display("[TB] FAIL hwm_peak: got hwm=%0d cnt=%0d want 20/0", hwm, count);
    end
    hwm_clr = 1'b1;
    tick();
    hwm_clr = 1'b0;
    #1;
    n_cmp++;
    if (hwm !== '0) begin
      n_fail++;
      $display("[TB] FAIL hwm_clear: got %0d want 0", hwm);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_drain();
    test_stream();
    test_midstream_reset();
`ifdef FIFO_HWM_EN
    test_hwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
